serial_adapter: RTL and testbench

SERIAL_ADAPTER -- requirements
Module: serial_adapter

---
 rtl/serial_adapter.sv | 218 +++++++++++++++++++++
 tb/tb_serial_adapter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adapter.sv
// serial_adapter: bridges a 32-bit valid/ready host word stream to a simple
// memory request/response port. The host sends a three-word header
// (CMD, ADDR, LEN). Writes are followed by LEN+1 data words. Reads return
// LEN+1 words on the serial output. Unknown commands set a sticky error flag.
module serial_adapter #(
    parameter int ADDR_STEP = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        serial_in_valid,
    output logic        serial_in_ready,
    input  logic [31:0] serial_in_bits,
    output logic        serial_out_valid,
    input  logic        serial_out_ready,
    output logic [31:0] serial_out_bits,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_write,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        error
);

    typedef enum logic [2:0] {
        ST_CMD   = 3'd0,
        ST_ADDR  = 3'd1,
        ST_LEN   = 3'd2,
        ST_WDATA = 3'd3,
        ST_WREQ  = 3'd4,
        ST_RREQ  = 3'd5,
        ST_RRESP = 3'd6,
        ST_RDATA = 3'd7
    } state_t;

    localparam logic [31:0] CMD_READ  = 32'd0;
    localparam logic [31:0] CMD_WRITE = 32'd1;
    localparam logic [31:0] ADDR_INC  = 32'(ADDR_STEP);

    state_t      state_q, state_d;
    logic [31:0] cmd_q,   cmd_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] len_q,   len_d;
    logic [31:0] cnt_q,   cnt_d;
    logic [31:0] data_q,  data_d;
    logic        error_q, error_d;

    // The host port is open in the header states and while waiting for write data.
    logic in_open_s;
    logic in_fire_s;
    logic last_word_s;

    assign in_open_s   = (state_q == ST_CMD)  || (state_q == ST_ADDR) ||
                         (state_q == ST_LEN)  || (state_q == ST_WDATA);
    assign in_fire_s   = serial_in_valid && in_open_s;
    // The counter runs 0..LEN inclusive, so a full 32-bit LEN gives 2^32 words.
    assign last_word_s = (cnt_q == len_q);

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_CMD;
            cmd_q   <= 32'd0;
            addr_q  <= 32'd0;
            len_q   <= 32'd0;
            cnt_q   <= 32'd0;
            data_q  <= 32'd0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            error_q <= error_d;
        end
    end

    // Next-state and datapath update logic; every state holds until its handshake completes.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        error_d = error_q;
        case (state_q)
            ST_CMD: begin
                if (in_fire_s) begin
                    cmd_d   = serial_in_bits;
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_ADDR: begin
                if (in_fire_s) begin
                    addr_d  = serial_in_bits;
                    state_d = ST_LEN;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_LEN: begin
                if (in_fire_s) begin
                    len_d = serial_in_bits;
                    cnt_d = 32'd0;
                    if (cmd_q == CMD_WRITE) begin
                        state_d = ST_WDATA;
                    end else if (cmd_q == CMD_READ) begin
                        state_d = ST_RREQ;
                    end else begin
                        // Header fully consumed; flag it and skip the memory phase.
                        error_d = 1'b1;
                        state_d = ST_CMD;
                    end
                end else begin
                    state_d = ST_LEN;
                end
            end
            ST_WDATA: begin
                if (in_fire_s) begin
                    data_d  = serial_in_bits;
                    state_d = ST_WREQ;
                end else begin
                    state_d = ST_WDATA;
                end
            end
            ST_WREQ: begin
                if (mem_req_ready) begin
                    if (last_word_s) begin
                        state_d = ST_CMD;
                    end else begin
                        cnt_d   = cnt_q + 32'd1;
                        addr_d  = addr_q + ADDR_INC;
                        state_d = ST_WDATA;
                    end
                end else begin
                    state_d = ST_WREQ;
                end
            end
            ST_RREQ: begin
                if (mem_req_ready) begin
                    state_d = ST_RRESP;
                end else begin
                    state_d = ST_RREQ;
                end
            end
            ST_RRESP: begin
                if (mem_resp_valid) begin
                    data_d  = mem_resp_data;
                    state_d = ST_RDATA;
                end else begin
                    state_d = ST_RRESP;
                end
            end
            ST_RDATA: begin
                if (serial_out_ready) begin
                    if (last_word_s) begin
                        state_d = ST_CMD;
                    end else begin
                        cnt_d   = cnt_q + 32'd1;
                        addr_d  = addr_q + ADDR_INC;
                        state_d = ST_RREQ;
                    end
                end else begin
                    state_d = ST_RDATA;
                end
            end
            default: begin
                state_d = ST_CMD;
            end
        endcase
    end

    // Output decode from the registered state; everything is forced low while reset is held.
    always_comb begin
        serial_in_ready  = 1'b0;
        serial_out_valid = 1'b0;
        serial_out_bits  = 32'd0;
        mem_req_valid    = 1'b0;
        mem_req_write    = 1'b0;
        mem_req_addr     = 32'd0;
        mem_req_data     = 32'd0;
        error            = 1'b0;
        if (reset) begin
            error = 1'b0;
        end else begin
            error = error_q;
            case (state_q)
                ST_CMD, ST_ADDR, ST_LEN, ST_WDATA: begin
                    serial_in_ready = 1'b1;
                end
                ST_WREQ: begin
                    mem_req_valid = 1'b1;
                    mem_req_write = 1'b1;
                    mem_req_addr  = addr_q;
                    mem_req_data  = data_q;
                end
                ST_RREQ: begin
                    mem_req_valid = 1'b1;
                    mem_req_addr  = addr_q;
                end
                ST_RDATA: begin
                    serial_out_valid = 1'b1;
                    serial_out_bits  = data_q;
                end
                default: begin
                    serial_in_ready = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adapter.sv
// Scoreboard bench for serial_adapter: transaction generators push host words,
// expected memory requests and expected serial output words into queues;
// independent driver, memory responder and monitor processes consume them.
module tb_serial_adapter;

    localparam int STEP = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        serial_in_valid = 1'b0;
    logic [31:0] serial_in_bits = 32'd0;
    logic        serial_out_ready = 1'b0;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = 32'd0;
    logic        serial_in_ready;
    logic        serial_out_valid;
    logic [31:0] serial_out_bits;
    logic        mem_req_valid;
    logic        mem_req_write;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic        error;

    serial_adapter #(.ADDR_STEP(STEP)) dut (
        .clock(clock), .reset(reset),
        .serial_in_valid(serial_in_valid), .serial_in_ready(serial_in_ready),
        .serial_in_bits(serial_in_bits),
        .serial_out_valid(serial_out_valid), .serial_out_ready(serial_out_ready),
        .serial_out_bits(serial_out_bits),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .error(error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    logic [31:0] host_q[$];
    req_t        exp_req_q[$];
    logic [31:0] rd_data_q[$];
    logic [31:0] exp_out_q[$];
    int          wr_cyc_q[$];
    int          out_cyc_q[$];

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    bit  fast = 1'b0, out_toggle = 1'b0, resp_hold = 1'b0, force_stray = 1'b0;
    bit  rd_pending = 1'b0, resp_real = 1'b0, exp_error = 1'b0;
    int  stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference model: a write burst touches base + i*STEP with the i-th data word.
    task automatic gen_write(input logic [31:0] base, input int len,
                             input logic [31:0] first, input logic [31:0] dstep);
        logic [31:0] d;
        host_q.push_back(32'd1);
        host_q.push_back(base);
        host_q.push_back(32'(len));
        for (int i = 0; i <= len; i++) begin
            d = first + 32'(i) * dstep;
            host_q.push_back(d);
            exp_req_q.push_back('{wr: 1'b1, addr: base + 32'(i * STEP), data: d});
        end
    endtask

    // Reference model: a read burst requests each address and echoes what memory returns.
    task automatic gen_read(input logic [31:0] base, input int len,
                            input logic [31:0] first, input logic [31:0] dstep);
        logic [31:0] d;
        host_q.push_back(32'd0);
        host_q.push_back(base);
        host_q.push_back(32'(len));
        for (int i = 0; i <= len; i++) begin
            d = first + 32'(i) * dstep;
            exp_req_q.push_back('{wr: 1'b0, addr: base + 32'(i * STEP), data: 32'd0});
            rd_data_q.push_back(d);
            exp_out_q.push_back(d);
        end
    endtask

    task automatic gen_bad(input logic [31:0] cmd, input logic [31:0] a, input logic [31:0] l);
        host_q.push_back(cmd);
        host_q.push_back(a);
        host_q.push_back(l);
        exp_error = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((host_q.size() != 0 || exp_req_q.size() != 0 || exp_out_q.size() != 0) && n < 4000) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        chk({tag, "_drained"}, 32'(n < 4000), 32'd1);
        chk({tag, "_idle_in_ready"}, 32'(serial_in_ready), 32'd1);
        chk({tag, "_idle_req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({tag, "_idle_out_valid"}, 32'(serial_out_valid), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'(exp_error));
    endtask

    // Host driver: presents host_q[0] until accepted, then moves to the next word.
    initial begin
        bit in_fire;
        forever begin
            @(negedge clock);
            in_fire = serial_in_valid && serial_in_ready;
            @(posedge clock);
            #1;
            if (in_fire && host_q.size() != 0) void'(host_q.pop_front());
            if (host_q.size() != 0 && (fast || $urandom_range(0, 3) != 0)) begin
                serial_in_valid = 1'b1;
                serial_in_bits  = host_q[0];
            end else begin
                serial_in_valid = 1'b0;
                serial_in_bits  = $urandom;
            end
        end
    end

    // Memory responder and host output-ready driver.
    initial begin
        bit rd_fire;
        forever begin
            @(negedge clock);
            rd_fire = mem_req_valid && mem_req_ready && !mem_req_write;
            @(posedge clock);
            #1;
            if (mem_resp_valid && resp_real) rd_pending = 1'b0;
            if (rd_fire) rd_pending = 1'b1;
            resp_real      = 1'b0;
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
            if (rd_pending) begin
                if (!resp_hold && rd_data_q.size() != 0 && (fast || $urandom_range(0, 2) == 0)) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = rd_data_q.pop_front();
                    resp_real      = 1'b1;
                end
            end else if (force_stray || $urandom_range(0, 7) == 0) begin
                mem_resp_valid = 1'b1;
            end
            if (stall_cnt > 0) begin
                mem_req_ready = 1'b0;
                if (mem_req_valid) stall_cnt--;
            end else begin
                mem_req_ready = fast ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            serial_out_ready = fast ? 1'b1 : (out_toggle ? ~serial_out_ready : ($urandom_range(0, 2) != 0));
        end
    end

    // Monitor: scoreboard pops on every completed handshake, plus hold-stable checks under stall.
    initial begin
        req_t        e, held;
        logic [31:0] held_out;
        bit          req_stall = 1'b0, out_stall = 1'b0;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                req_stall = 1'b0;
                out_stall = 1'b0;
            end else begin
                if (req_stall) begin
                    chk("req_hold_valid", 32'(mem_req_valid), 32'd1);
                    chk("req_hold_write", 32'(mem_req_write), 32'(held.wr));
                    chk("req_hold_addr", mem_req_addr, held.addr);
                    chk("req_hold_data", mem_req_data, held.data);
                end
                if (out_stall) begin
                    chk("out_hold_valid", 32'(serial_out_valid), 32'd1);
                    chk("out_hold_bits", serial_out_bits, held_out);
                end
                req_stall = mem_req_valid && !mem_req_ready;
                held      = '{wr: mem_req_write, addr: mem_req_addr, data: mem_req_data};
                out_stall = serial_out_valid && !serial_out_ready;
                held_out  = serial_out_bits;
                if (mem_req_valid && mem_req_ready) begin
                    if (exp_req_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_req: got addr %08h, required no request", mem_req_addr);
                    end else begin
                        e = exp_req_q.pop_front();
                        chk("req_write", 32'(mem_req_write), 32'(e.wr));
                        chk("req_addr", mem_req_addr, e.addr);
                        chk("req_data", mem_req_data, e.data);
                        if (mem_req_write) wr_cyc_q.push_back(cyc);
                    end
                end
                if (serial_out_valid && serial_out_ready) begin
                    if (exp_out_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_out: got %08h, required no word", serial_out_bits);
                    end else begin
                        chk("out_bits", serial_out_bits, exp_out_q.pop_front());
                        out_cyc_q.push_back(cyc);
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        // Reset state: every output low while reset is held.
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready", 32'(serial_in_ready), 32'd0);
        chk("rst_out_valid", 32'(serial_out_valid), 32'd0);
        chk("rst_out_bits", serial_out_bits, 32'd0);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_req_write", 32'(mem_req_write), 32'd0);
        chk("rst_req_addr", mem_req_addr, 32'd0);
        chk("rst_req_data", mem_req_data, 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("in_ready_after_reset", 32'(serial_in_ready), 32'd1);

        // Directed write burst at full speed: one write every 2 cycles.
        fast = 1'b1;
        wr_cyc_q.delete();
        gen_write(32'h0000_1000, 2, 32'h0000_000A, 32'd1);
        wait_idle("wr_burst");
        chk("wr_count", 32'(wr_cyc_q.size()), 32'd3);
        if (wr_cyc_q.size() == 3) begin
            chk("wr_spacing0", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'd2);
            chk("wr_spacing1", 32'(wr_cyc_q[2] - wr_cyc_q[1]), 32'd2);
        end

        // Directed read burst at full speed: one output word every 3 cycles.
        out_cyc_q.delete();
        gen_read(32'h0000_2000, 1, 32'h0000_0011, 32'h0000_0011);
        wait_idle("rd_burst");
        chk("rd_count", 32'(out_cyc_q.size()), 32'd2);
        if (out_cyc_q.size() == 2) chk("rd_spacing", 32'(out_cyc_q[1] - out_cyc_q[0]), 32'd3);
        fast = 1'b0;

        // Unknown command, then a normal write.
        gen_bad(32'd7, 32'd0, 32'd0);
        wait_idle("bad_cmd");
        gen_write($urandom & 32'hFFFF_FFFC, 2, $urandom, $urandom);
        wait_idle("after_bad");

        // Address wrap.
        gen_write(32'hFFFF_FFFC, 1, $urandom, $urandom);
        wait_idle("wrap");

        // Back-pressure: memory stalls 5 cycles, output ready toggles.
        out_toggle = 1'b1;
        stall_cnt  = 5;
        gen_write(32'h0000_4000, 3, $urandom, $urandom);
        wait_idle("bp_write");
        stall_cnt = 5;
        gen_read(32'h0000_5000, 3, $urandom, $urandom);
        wait_idle("bp_read");
        out_toggle = 1'b0;

        // Reset while waiting for read data, then a stray response.
        resp_hold = 1'b1;
        host_q.push_back(32'd0);
        host_q.push_back(32'h0000_3000);
        host_q.push_back(32'd0);
        exp_req_q.push_back('{wr: 1'b0, addr: 32'h0000_3000, data: 32'd0});
        n = 0;
        while (!rd_pending && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk("rresp_reached", 32'(rd_pending), 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset       = 1'b0;
        rd_pending  = 1'b0;
        force_stray = 1'b1;
        exp_error   = 1'b0;
        @(negedge clock);
        force_stray = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("stray_out_valid", 32'(serial_out_valid), 32'd0);
            chk("stray_in_ready", 32'(serial_in_ready), 32'd1);
        end
        resp_hold = 1'b0;

        // Randomized traffic against the reference model.
        for (int t = 0; t < 40; t++) begin
            int          kind;
            int          len;
            logic [31:0] base;
            logic [31:0] c;
            kind = $urandom_range(0, 9);
            len  = $urandom_range(0, 5);
            base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            if (kind == 0) begin
                c = $urandom;
                if (c < 32'd2) c = 32'd2;
                gen_bad(c, $urandom, $urandom);
            end else if (kind < 5) begin
                gen_write(base, len, $urandom, $urandom);
            end else begin
                gen_read(base, len, $urandom, $urandom);
            end
            if (t % 5 == 4) wait_idle("random");
        end
        wait_idle("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
